// File: rtl/ins_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ins_fetch_pkg
// Shared kestrel2 definitions for the instruction fetch unit: reset word
// address default, fetch buffer depths, FSM state encoding, buffer entry
// layout and the word-address increment helper.
// Ports: none (package).
// ----------------------------------------------------------------------------
package ins_fetch_pkg;

    // Word address fetched first after reset.
    localparam logic [15:1] FETCH_RESET_ADR = 15'h0000;

    // Buffer depth with and without prefetching.
    localparam int FETCH_DEPTH_PF   = 2;
    localparam int FETCH_DEPTH_NOPF = 1;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DROP = 2'b10
    } fetch_state_e;

    // One buffered instruction: the data word plus the word address it came from.
    typedef struct packed {
        logic [15:0] ins;
        logic [15:1] pc;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

    // Next word address; wraps 15'h7FFF -> 15'h0000 by truncation.
    function automatic logic [15:1] next_word_adr(input logic [15:1] adr);
        return adr + 15'd1;
    endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// ----------------------------------------------------------------------------
// ins_fetch_if
// Wishbone instruction-bus signals between the fetch unit (master) and the
// program memory (slave). Classic single-read cycles only.
// Signals:
//   ins_adr_o [15:1] word address        (master -> slave)
//   ins_cyc_o        bus cycle active     (master -> slave)
//   ins_stb_o        strobe               (master -> slave)
//   ins_dat_i [15:0] read data            (slave -> master)
//   ins_ack_i        cycle termination    (slave -> master)
// ----------------------------------------------------------------------------
interface ins_fetch_if;

    logic [15:1] ins_adr_o;
    logic        ins_cyc_o;
    logic        ins_stb_o;
    logic [15:0] ins_dat_i;
    logic        ins_ack_i;

    modport master (
        output ins_adr_o,
        output ins_cyc_o,
        output ins_stb_o,
        input  ins_dat_i,
        input  ins_ack_i
    );

    modport slave (
        input  ins_adr_o,
        input  ins_cyc_o,
        input  ins_stb_o,
        output ins_dat_i,
        output ins_ack_i
    );

endinterface

// File: rtl/ins_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small instruction buffer for the fetch unit. DEPTH is 1 or 2. The head
// entry is always a register, so the decoder never sees bus data directly.
// Push and pop in the same cycle both complete. Flush empties the buffer and
// takes priority over push/pop. Pushing into a full buffer without a
// simultaneous pop is not supported; the caller only issues a bus request
// when a slot is free.
// Ports:
//   sys_clk_i, sys_rst_i  clock, synchronous active-high reset
//   flush                 discard all entries
//   push, push_data       write one entry at the tail
//   pop                   consume the head entry (ignored when empty)
//   head_data             head entry (RST_VAL after reset)
//   full, empty           occupancy flags
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int               DEPTH   = 1,
    parameter int               WIDTH   = 31,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    generate
        if (DEPTH == 1) begin : g_one

            logic [WIDTH-1:0] ent0_q;
            logic             vld_q;

            always_ff @(posedge sys_clk_i) begin
                if (sys_rst_i) begin
                    ent0_q <= RST_VAL;
                    vld_q  <= 1'b0;
                end else if (flush) begin
                    vld_q <= 1'b0;
                end else if (push) begin
                    // Covers push alone and push with pop of the old head.
                    ent0_q <= push_data;
                    vld_q  <= 1'b1;
                end else if (pop) begin
                    vld_q <= 1'b0;
                end
            end

            assign head_data = ent0_q;
            assign full      = vld_q;
            assign empty     = ~vld_q;

        end else begin : g_two

            logic [WIDTH-1:0] ent0_q;
            logic [WIDTH-1:0] ent1_q;
            logic [1:0]       cnt_q;
            logic             pop_ok;

            assign pop_ok = pop & (cnt_q != 2'd0);

            always_ff @(posedge sys_clk_i) begin
                if (sys_rst_i) begin
                    ent0_q <= RST_VAL;
                    ent1_q <= RST_VAL;
                    cnt_q  <= 2'd0;
                end else if (flush) begin
                    cnt_q <= 2'd0;
                end else begin
                    case ({pop_ok, push})
                        2'b10: begin
                            // Only shift when a second entry exists; a lone
                            // head simply becomes invalid and keeps its value.
                            if (cnt_q == 2'd2) begin
                                ent0_q <= ent1_q;
                            end
                            cnt_q <= cnt_q - 2'd1;
                        end
                        2'b01: begin
                            if (cnt_q == 2'd0) begin
                                ent0_q <= push_data;
                            end else begin
                                ent1_q <= push_data;
                            end
                            cnt_q <= cnt_q + 2'd1;
                        end
                        2'b11: begin
                            if (cnt_q == 2'd1) begin
                                ent0_q <= push_data;
                            end else begin
                                ent0_q <= ent1_q;
                                ent1_q <= push_data;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            assign head_data = ent0_q;
            assign full      = (cnt_q == 2'd2);
            assign empty     = (cnt_q == 2'd0);

        end
    endgenerate

endmodule

// File: rtl/ins_fetch.sv
// ----------------------------------------------------------------------------
// ins_fetch
// Instruction fetch unit: Wishbone read master that fills a small buffer
// and offers the head word to the decoder. A redirect (br_i) flushes the
// buffer, reloads the fetch pointer and turns an outstanding bus cycle into
// one whose data is discarded.
//
// Build option: define FETCH_PREFETCH_EN for a 2-entry buffer that fetches
// ahead while the head waits; otherwise a 1-entry buffer is used and the
// next fetch starts only after the head is taken or flushed.
//
// Ports:
//   sys_clk_i              clock
//   sys_rst_i              synchronous active-high reset
//   ins_bus (master)       Wishbone instruction bus (see ins_fetch_if)
//   fet_valid_o            head word available
//   fet_ins_o [15:0]       head instruction
//   fet_pc_o  [15:1]       head word address
//   fet_take_i             decoder consumes head (with fet_valid_o)
//   br_i, br_adr_i [15:1]  redirect request and word target
//
// state      | meaning
// -----------+-------------------------------------------------------------
// FETCH_IDLE | no bus request
// FETCH_REQ  | request outstanding, data goes to the buffer on ack
// FETCH_DROP | request outstanding after a redirect, data discarded on ack
// ----------------------------------------------------------------------------
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter logic [15:1] RESET_ADR = FETCH_RESET_ADR
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_i,
    ins_fetch_if.master  ins_bus,
    output logic         fet_valid_o,
    output logic [15:0]  fet_ins_o,
    output logic [15:1]  fet_pc_o,
    input  logic         fet_take_i,
    input  logic         br_i,
    input  logic [15:1]  br_adr_i
);

`ifdef FETCH_PREFETCH_EN
    localparam int BUF_DEPTH = FETCH_DEPTH_PF;
`else
    localparam int BUF_DEPTH = FETCH_DEPTH_NOPF;
`endif

    localparam fetch_entry_t BUF_RST = '{ins: 16'h0000, pc: RESET_ADR};

    fetch_state_e state_q;
    fetch_state_e state_d;

    // fpc_q is the next address to fetch; adr_q is the address driven on the
    // bus, frozen for the whole cycle even if a redirect moves fpc_q.
    logic [15:1] fpc_q;
    logic [15:1] adr_q;

    logic         buf_full;
    logic         buf_empty;
    logic         buf_push;
    logic         buf_pop;
    logic         req_start;
    fetch_entry_t push_ent;
    fetch_entry_t head_ent;
    logic [FETCH_ENTRY_W-1:0] head_vec;

    always_comb begin
        state_d   = state_q;
        buf_push  = 1'b0;
        req_start = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (!buf_full && !br_i) begin
                    state_d   = FETCH_REQ;
                    req_start = 1'b1;
                end
            end
            FETCH_REQ: begin
                if (ins_bus.ins_ack_i) begin
                    state_d  = FETCH_IDLE;
                    // A redirect on the ack edge wins; the word is stale.
                    buf_push = ~br_i;
                end else if (br_i) begin
                    state_d = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (ins_bus.ins_ack_i) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= FETCH_IDLE;
            fpc_q   <= RESET_ADR;
            adr_q   <= RESET_ADR;
        end else begin
            state_q <= state_d;
            if (br_i) begin
                fpc_q <= br_adr_i;
            end else if (buf_push) begin
                fpc_q <= next_word_adr(fpc_q);
            end
            if (req_start) begin
                adr_q <= fpc_q;
            end
        end
    end

    assign buf_pop  = fet_take_i & ~buf_empty;
    assign push_ent = '{ins: ins_bus.ins_dat_i, pc: adr_q};

    fetch_fifo #(
        .DEPTH   (BUF_DEPTH),
        .WIDTH   (FETCH_ENTRY_W),
        .RST_VAL (BUF_RST)
    ) u_fifo (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .flush     (br_i),
        .push      (buf_push),
        .push_data (push_ent),
        .pop       (buf_pop),
        .head_data (head_vec),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign head_ent = fetch_entry_t'(head_vec);

    assign ins_bus.ins_cyc_o = (state_q != FETCH_IDLE);
    assign ins_bus.ins_stb_o = (state_q != FETCH_IDLE);
    assign ins_bus.ins_adr_o = adr_q;

    assign fet_valid_o = ~buf_empty;
    assign fet_ins_o   = head_ent.ins;
    assign fet_pc_o    = head_ent.pc;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter RESET_ADR, default 15'h0000, word address fetched first after reset.
REQ-002 SHALL have input sys_clk_i, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have input sys_rst_i, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have outputs ins_adr_o [15:1], ins_cyc_o and ins_stb_o (1 bit each), a Wishbone instruction-bus master request.
REQ-005 SHALL have inputs ins_dat_i [15:0] (read data) and ins_ack_i (1 bit, cycle termination).
REQ-006 SHALL have outputs fet_valid_o (1), fet_ins_o [15:0] and fet_pc_o [15:1], the instruction offered to the decoder.
REQ-007 SHALL have input fet_take_i (1 bit); the decoder consumes the head word when it is high in the same cycle as fet_valid_o.
REQ-008 SHALL have inputs br_i (1 bit) and br_adr_i [15:1], a redirect request and its word target.

Function
REQ-009 SHALL hold ins_cyc_o=ins_stb_o=1 with ins_adr_o stable from request start until the cycle ins_acks_i is sampled high; never deassert mid-cycle.
REQ-010 SHALL tolerate any number of wait states, including the one-wait-state, non-back-to-back ack of the block-RAM program memory.
REQ-011 SHALL use states IDLE (no request), REQ (request outstanding) and DROP (request outstanding, result to be discarded).
REQ-012 IDLE->REQ when the buffer has a free slot and br_i=0; REQ->IDLE on ack; REQ->DROP on br_i without ack; DROP->IDLE on ack.
REQ-013 On ack in REQ SHALL write {ins_dat_i, ins_adr_o} into the buffer and increment the fetch pointer by one word, wrapping 15'h7FFF->15'h0000.
REQ-014 On ack in DROP SHALL discard ins_dat_i and leave the buffer unchanged.
REQ-015 br_i SHALL flush the buffer and load the fetch pointer with br_adr_i in the same edge, so fet_valid_o=0 the next cycle; br_i dominates fet_take_i and any simultaneous ack.
REQ-016 fet_ins_o and fet_pc_o SHALL come from the buffer head register, never combinationally from ins_dat_i; min. latency from ack to fet_valid_o=1 is one cycle.
REQ-017 Take and write in the same cycle SHALL both complete; a write into a full buffer SHALL never be issued.
REQ-018 fet_ins_o/fet_pc_o SHALL hold stable while fet_valid_o=1 and fet_take_i=0.

Reset
REQ-019 sys_rst_i=1 SHALL force: state IDLE, buffer empty, fetch pointer RESET_ADR, ins_cyc_o=ins_stb_o=0, fet_valid_o=0, ins_adr_o=RESET_ADR, fet_ins_o=16'h0000, fet_pc_o=RESET_ADR.
REQ-020 Reset mid-cycle SHALL abandon the bus cycle immediately; an ack in the first post-reset cycle SHALL be ignored.
REQ-021 First request SHALL start the cycle after sys_rst_i falls.

Configuration
REQ-022 With FETCH_PREFETCH_EN defined SHALL use a 2-entry buffer and issue the next request while the head waits to be taken.
REQ-023 Without FETCH_PREFETCH_EN SHALL use a 1-entry buffer; a new request starts only after the head is taken (or flushed).

Structure
REQ-024 RESET_ADR default, buffer depths (1/2) and state encodings SHALL live in the shared kestrel2 package.
REQ-025 The buffer SHALL be sub-module fetch_fifo (depth parameter, 31-bit entries, push/pop/flush, full/empty).

Verification
REQ-026 Reset release, memory acks one cycle after stb -> ins_adr_o 0,1,2 in order; fet_pc_o 0,1,2 with data 16'h1111, 16'h2222, 16'h3333.
REQ-027 fet_take_i held 0 (prefetch on) -> exactly two words buffered, ins_cyc_o=0 afterwards, fet_ins_o stays 16'h1111.
REQ-028 br_i=1, br_adr_i=15'h0100 while request to 15'h0003 outstanding -> that ack dropped, next ins_adr_o=15'h0100, first fet_pc_o 15'h0100.
REQ-029 Fetch pointer 15'h7FFF, ack -> next ins_adr_o 15'h0000, fet_pc_o 15'h7FFF.
REQ-030 sys_rst_i asserted while ins_stb_o=1 -> next cycle ins_cyc_o=0, fet_valid_o=0, stray ack ignored, refetch from 15'h0000.
REQ-031 Prefetch off, 3-wait-state slave -> one request outstanding at most, never two words buffered.
